// File: rtl/fp_mul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake.
// Subnormal inputs are treated as zero, tiny results flush to zero, and rounding is to nearest, ties to even.
module fp_mul_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [EXP_W+MAN_W:0] a_i,
  input  logic [EXP_W+MAN_W:0] b_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [EXP_W+MAN_W:0] product_o,
  output logic [3:0]           flags_o
);

  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned PW = 2 * MAN_W + 2;
  localparam int Bias   = (1 << (EXP_W - 1)) - 1;
  localparam int ExpMax = (1 << EXP_W) - 1;

  typedef logic signed [EXP_W+1:0] exp_t;

  localparam exp_t BiasE   = exp_t'(Bias);
  localparam exp_t ExpMaxE = exp_t'(ExpMax);
  localparam logic [W-1:0] CanonNan = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic en;

  // S1: unpack / classify / exponent sum
  logic             sign_a, sign_b;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] man_a, man_b;
  logic             zero_a, zero_b, inf_a, inf_b, nan_a, nan_b, inf_zero;

  logic             s1_valid_q;
  logic             s1_sign_d, s1_sign_q;
  logic             s1_nan_d, s1_nan_q;
  logic             s1_inv_d, s1_inv_q;
  logic             s1_inf_d, s1_inf_q;
  logic             s1_zero_d, s1_zero_q;
  exp_t             s1_exp_d, s1_exp_q;
  logic [MAN_W:0]   s1_ma_d, s1_ma_q;
  logic [MAN_W:0]   s1_mb_d, s1_mb_q;

  always_comb begin
    {sign_a, exp_a, man_a} = a_i;
    {sign_b, exp_b, man_b} = b_i;
    zero_a   = (exp_a == '0);
    zero_b   = (exp_b == '0);
    inf_a    = (&exp_a) & (man_a == '0);
    inf_b    = (&exp_b) & (man_b == '0);
    nan_a    = (&exp_a) & (man_a != '0);
    nan_b    = (&exp_b) & (man_b != '0);
    inf_zero = (inf_a & zero_b) | (zero_a & inf_b);

    s1_sign_d = sign_a ^ sign_b;
    s1_nan_d  = nan_a | nan_b | inf_zero;
    s1_inv_d  = inf_zero & ~(nan_a | nan_b);
    s1_inf_d  = inf_a | inf_b;
    s1_zero_d = zero_a | zero_b;
    s1_exp_d  = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BiasE;
    s1_ma_d   = {1'b1, man_a};
    s1_mb_d   = {1'b1, man_b};
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_nan_q   <= 1'b0;
      s1_inv_q   <= 1'b0;
      s1_inf_q   <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_exp_q   <= '0;
      s1_ma_q    <= '0;
      s1_mb_q    <= '0;
    end else if (en) begin
      s1_valid_q <= valid_i;
      s1_sign_q  <= s1_sign_d;
      s1_nan_q   <= s1_nan_d;
      s1_inv_q   <= s1_inv_d;
      s1_inf_q   <= s1_inf_d;
      s1_zero_q  <= s1_zero_d;
      s1_exp_q   <= s1_exp_d;
      s1_ma_q    <= s1_ma_d;
      s1_mb_q    <= s1_mb_d;
    end
  end

  // S2: full-width mantissa multiply
  logic          s2_valid_q;
  logic          s2_sign_q, s2_nan_q, s2_inv_q, s2_inf_q, s2_zero_q;
  exp_t          s2_exp_q;
  logic [PW-1:0] s2_prod_d, s2_prod_q;

  always_comb begin
    s2_prod_d = PW'(s1_ma_q) * PW'(s1_mb_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s2_valid_q <= 1'b0;
      s2_sign_q  <= 1'b0;
      s2_nan_q   <= 1'b0;
      s2_inv_q   <= 1'b0;
      s2_inf_q   <= 1'b0;
      s2_zero_q  <= 1'b0;
      s2_exp_q   <= '0;
      s2_prod_q  <= '0;
    end else if (en) begin
      s2_valid_q <= s1_valid_q;
      s2_sign_q  <= s1_sign_q;
      s2_nan_q   <= s1_nan_q;
      s2_inv_q   <= s1_inv_q;
      s2_inf_q   <= s1_inf_q;
      s2_zero_q  <= s1_zero_q;
      s2_exp_q   <= s1_exp_q;
      s2_prod_q  <= s2_prod_d;
    end
  end

  // S3: normalize / round / pack
  logic           prod_msb, guard, sticky, round_up, inexact;
  logic [MAN_W-1:0] mant;
  logic [MAN_W:0] mant_rnd;
  exp_t           exp_norm, exp_fin;
  logic           valid_q;
  logic [W-1:0]   product_d, product_q;
  logic [3:0]     flags_d, flags_q;

  always_comb begin
    prod_msb = s2_prod_q[PW-1];
    // A product in [2,4) drops one extra low bit and bumps the exponent.
    mant     = prod_msb ? s2_prod_q[2*MAN_W:MAN_W+1] : s2_prod_q[2*MAN_W-1:MAN_W];
    guard    = prod_msb ? s2_prod_q[MAN_W] : s2_prod_q[MAN_W-1];
    sticky   = prod_msb ? (|s2_prod_q[MAN_W-1:0]) : (|s2_prod_q[MAN_W-2:0]);
    round_up = guard & (sticky | mant[0]);
    inexact  = guard | sticky;
    mant_rnd = {1'b0, mant} + {{MAN_W{1'b0}}, round_up};
    exp_norm = s2_exp_q + $signed({{(EXP_W+1){1'b0}}, prod_msb});
    exp_fin  = exp_norm + $signed({{(EXP_W+1){1'b0}}, mant_rnd[MAN_W]});

    product_d = {s2_sign_q, exp_fin[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
    flags_d   = {3'b000, inexact};
    if (s2_nan_q) begin
      product_d = CanonNan;
      flags_d   = {s2_inv_q, 3'b000};
    end else if (s2_inf_q) begin
      product_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d   = 4'b0000;
    end else if (s2_zero_q) begin
      product_d = {s2_sign_q, {(W-1){1'b0}}};
      flags_d   = 4'b0000;
    end else if (exp_fin >= ExpMaxE) begin
      product_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flags_d   = 4'b0101;
    end else if (exp_fin <= exp_t'(0)) begin
      product_d = {s2_sign_q, {(W-1){1'b0}}};
      flags_d   = {2'b00, 1'b1, inexact};
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q   <= 1'b0;
      product_q <= '0;
      flags_q   <= '0;
    end else if (en) begin
      valid_q   <= s2_valid_q;
      product_q <= product_d;
      flags_q   <= flags_d;
    end
  end

  // The whole pipe advances together; a stalled output freezes every stage.
  assign en        = ready_i | ~valid_q;
  assign ready_o   = en;
  assign valid_o   = valid_q;
  assign product_o = product_q;
  assign flags_o   = flags_q;

endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe: single-precision instance plus a half-precision build.
module tb_fp_mul_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        valid_a, ready_o_a, ready_a, valid_o_a;
  logic [31:0] a_a, b_a, prod_a;
  logic [3:0]  flags_a;
  logic        valid_h, ready_o_h, ready_h, valid_o_h;
  logic [15:0] a_h, b_h, prod_h;
  logic [3:0]  flags_h;

  int n_checks = 0;
  int n_fail   = 0;

  fp_mul_pipe u_dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .valid_i  (valid_a),
    .ready_o  (ready_o_a),
    .a_i      (a_a),
    .b_i      (b_a),
    .valid_o  (valid_o_a),
    .ready_i  (ready_a),
    .product_o(prod_a),
    .flags_o  (flags_a)
  );

  fp_mul_pipe #(
    .EXP_W(5),
    .MAN_W(10)
  ) u_dut_h (
    .clk_i    (clk),
    .reset_i  (reset),
    .valid_i  (valid_h),
    .ready_o  (ready_o_h),
    .a_i      (a_h),
    .b_i      (b_h),
    .valid_o  (valid_o_h),
    .ready_i  (ready_h),
    .product_o(prod_h),
    .flags_o  (flags_h)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One isolated operation with ready_i held high; fmask selects which flag bits are checked.
  task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input logic [3:0] exp_f,
                        input logic [3:0] fmask, input string tag);
    @(negedge clk);
    if (half) begin
      a_h = a[15:0]; b_h = b[15:0]; valid_h = 1'b1;
    end else begin
      a_a = a; b_a = b; valid_a = 1'b1;
    end
    @(posedge clk); #1;
    valid_a = 1'b0;
    valid_h = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_early"}, half ? valid_o_h : valid_o_a, 64'd0);
    @(posedge clk); #1;
    check_eq({tag, "_valid"}, half ? valid_o_h : valid_o_a, 64'd1);
    check_eq({tag, "_prod"}, half ? {16'h0, prod_h} : prod_a, exp_p);
    check_eq({tag, "_flags"}, (half ? flags_h : flags_a) & fmask, exp_f);
  endtask

  logic [31:0] st_a [5];
  logic [31:0] st_b [5];
  logic [31:0] st_p [5];

  initial begin
    int  sent, got, stale;
    logic acc, xfer;
    logic [31:0] cap;

    st_a[0] = 32'h3F800000; st_b[0] = 32'h40000000; st_p[0] = 32'h40000000;
    st_a[1] = 32'hBF800000; st_b[1] = 32'h40400000; st_p[1] = 32'hC0400000;
    st_a[2] = 32'h3F800000; st_b[2] = 32'h40800000; st_p[2] = 32'h40800000;
    st_a[3] = 32'hBF800000; st_b[3] = 32'h40A00000; st_p[3] = 32'hC0A00000;
    st_a[4] = 32'h3F800000; st_b[4] = 32'h40C00000; st_p[4] = 32'h40C00000;

    reset = 1'b1;
    valid_a = 1'b0; a_a = '0; b_a = '0; ready_a = 1'b1;
    valid_h = 1'b0; a_h = '0; b_h = '0; ready_h = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_valid", valid_o_a, 64'd0);
    check_eq("rst_prod", prod_a, 64'd0);
    check_eq("rst_flags", flags_a, 64'd0);
    check_eq("rst_valid_h", valid_o_h, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_ready", ready_o_a, 64'd1);
    check_eq("rst_ready_h", ready_o_h, 64'd1);

    run_op(0, 32'h40000000, 32'h40400000, 32'h40C00000, 4'h0, 4'hF, "two_x_three");
    run_op(0, 32'h3F800001, 32'h3F800001, 32'h3F800002, 4'h1, 4'hF, "sticky");
    run_op(0, 32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'h0, 4'hF, "msb_norm");
    run_op(0, 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'h1, 4'hF, "tie_odd");
    run_op(0, 32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'h1, 4'hF, "tie_even");
    run_op(0, 32'h3FFFFFFE, 32'h3F800001, 32'h40000000, 4'h1, 4'hF, "rnd_carry");
    run_op(0, 32'hC0000000, 32'h40400000, 32'hC0C00000, 4'h0, 4'hF, "neg");
    run_op(0, 32'h7F800000, 32'h00000000, 32'h7FC00000, 4'h8, 4'hF, "inf_x_zero");
    run_op(0, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'h0, 4'hF, "nan_in");
    run_op(0, 32'hFF800000, 32'h40000000, 32'hFF800000, 4'h0, 4'hF, "inf_x_fin");
    run_op(0, 32'h80000000, 32'h40000000, 32'h80000000, 4'h0, 4'hF, "zero_x_fin");
    run_op(0, 32'h7F000000, 32'h7F000000, 32'h7F800000, 4'h5, 4'hF, "ovf");
    run_op(0, 32'h7F000000, 32'h40000000, 32'h7F800000, 4'h5, 4'hF, "ovf_edge");
    run_op(0, 32'h7F000000, 32'h3F800000, 32'h7F000000, 4'h0, 4'hF, "max_exp");
    run_op(0, 32'h00800000, 32'h00800000, 32'h00000000, 4'h2, 4'hE, "unf");
    run_op(0, 32'h00800000, 32'h3F000000, 32'h00000000, 4'h2, 4'hE, "unf_edge");
    run_op(0, 32'h00800000, 32'h3F800000, 32'h00800000, 4'h0, 4'hF, "min_norm");
    run_op(0, 32'h00400000, 32'h40000000, 32'h00000000, 4'h0, 4'hF, "daz");
    run_op(1, 32'h4000, 32'h4200, 32'h4600, 4'h0, 4'hF, "h_mul");
    run_op(1, 32'h7800, 32'h7800, 32'h7C00, 4'h5, 4'hF, "h_ovf");

    // Backpressure: five pairs offered while the sink stalls, then released.
    repeat (3) @(posedge clk);
    ready_a = 1'b0;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      if (cyc == 6) ready_a = 1'b1;
      valid_a = (sent < 5);
      if (sent < 5) begin
        a_a = st_a[sent];
        b_a = st_b[sent];
      end
      #1;
      acc  = valid_a & ready_o_a;
      xfer = valid_o_a & ready_a;
      cap  = prod_a;
      if (cyc == 5) begin
        check_eq("bp_accepts", sent, 64'd3);
        check_eq("bp_ready_low", ready_o_a, 64'd0);
        check_eq("bp_hold_valid", valid_o_a, 64'd1);
        check_eq("bp_hold_prod", prod_a, st_p[0]);
      end
      @(posedge clk);
      if (acc) sent++;
      if (xfer) begin
        check_eq("bp_order", cap, st_p[got]);
        got++;
      end
    end
    valid_a = 1'b0;
    check_eq("bp_count", got, 64'd5);

    // Reset with two operations in flight.
    repeat (3) @(posedge clk);
    @(negedge clk);
    a_a = 32'h40000000; b_a = 32'h40400000; valid_a = 1'b1;
    @(negedge clk);
    a_a = 32'h3FC00000; b_a = 32'h3FC00000;
    @(negedge clk);
    valid_a = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("rstmid_valid", valid_o_a, 64'd0);
    check_eq("rstmid_prod", prod_a, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (valid_o_a) stale++;
    end
    check_eq("rstmid_stale", stale, 64'd0);
    check_eq("rstmid_ready", ready_o_a, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
